prewish_mask_arbiter: RTL and testbench

Shares the blinky's single mask-load port (strobe plus 8-bit mask) between two mask requesters. Requester 0 is the button-driven mask generator; requester 1 is the periodic new-mask source. The block sits inside prewish_controller, between those sources and the blinky. It grants one load at a time, forwards the winning mask as a one-cycle strobe, and enforces a minimum gap between consecutive loads.

---
 rtl/prewish_mask_arbiter_pkg.sv | 20 ++
 rtl/prewish_mask_arbiter_gap_timer.sv | 30 +++
 rtl/prewish_mask_arbiter.sv | 93 +++++++++
 tb/tb_prewish_mask_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prewish_mask_arbiter_pkg.sv
// Shared state encoding, mask width and grant codes for the prewish mask arbiter.
package prewish_mask_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int unsigned PREWISH_MASK_W = 8;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_REQ0 = 2'b01;
  localparam logic [1:0] GNT_REQ1 = 2'b10;

  function automatic logic [1:0] gnt_code(input logic sel1);
    return sel1 ? GNT_REQ1 : GNT_REQ0;
  endfunction

endpackage

// File: rtl/prewish_mask_arbiter_gap_timer.sv
// Loadable down-counter enforcing the idle gap after each mask load; done when at zero.
module prewish_gap_timer #(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturates at zero so a stray enable never wraps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/prewish_mask_arbiter.sv
// Two-requester arbiter for the blinky mask-load port with enforced inter-load gap.
// Build option: PREWISH_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module prewish_mask_arbiter
  import prewish_mask_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MASK_W     = PREWISH_MASK_W
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              REQ0_STB_I,
  input  logic [MASK_W-1:0] REQ0_DAT_I,
  output logic              REQ0_ACK_O,
  input  logic              REQ1_STB_I,
  input  logic [MASK_W-1:0] REQ1_DAT_I,
  output logic              REQ1_ACK_O,
  output logic              STB_O,
  output logic [MASK_W-1:0] DAT_O,
  output logic [1:0]        GNT_O
);

  arb_state_t state;
  logic [1:0] arm;
  logic [1:0] elig;
  logic [1:0] grant_vec;
  logic       pick1;
  logic       grant;
  logic       gap_done;
`ifndef PREWISH_ARB_FIXED_PRIO_EN
  logic       last1;
`endif

  always_comb begin
    elig  = {REQ1_STB_I & arm[1], REQ0_STB_I & arm[0]};
    grant = (state == ST_IDLE) && (elig != 2'b00);
`ifdef PREWISH_ARB_FIXED_PRIO_EN
    pick1 = ~elig[0];
`else
    pick1 = (elig == 2'b11) ? ~last1 : elig[1];
`endif
    grant_vec = grant ? gnt_code(pick1) : GNT_NONE;
  end

  prewish_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk (CLK_I),
    .rst (RST_I),
    .load(state == ST_LOAD),
    .en  (state == ST_GAP),
    .done(gap_done)
  );

  // Arm bits are cleared at the grant edge so a strobe held high yields a single load.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= ST_IDLE;
      arm        <= '0;
      STB_O      <= 1'b0;
      REQ0_ACK_O <= 1'b0;
      REQ1_ACK_O <= 1'b0;
      DAT_O      <= '0;
      GNT_O      <= GNT_NONE;
`ifndef PREWISH_ARB_FIXED_PRIO_EN
      last1      <= 1'b1;
`endif
    end else begin
      arm        <= (arm | ~{REQ1_STB_I, REQ0_STB_I}) & ~grant_vec;
      STB_O      <= 1'b0;
      REQ0_ACK_O <= 1'b0;
      REQ1_ACK_O <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state      <= ST_LOAD;
            STB_O      <= 1'b1;
            REQ0_ACK_O <= ~pick1;
            REQ1_ACK_O <= pick1;
            DAT_O      <= pick1 ? REQ1_DAT_I : REQ0_DAT_I;
            GNT_O      <= grant_vec;
`ifndef PREWISH_ARB_FIXED_PRIO_EN
            last1      <= pick1;
`endif
          end
        end
        ST_LOAD: state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        ST_GAP:  if (gap_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prewish_mask_arbiter.sv
// Randomised and directed bench for prewish_mask_arbiter with GAP_CYCLES=16 and GAP_CYCLES=0 instances.
module tb_prewish_mask_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v  [2];
  logic       s0_v   [2];
  logic       s1_v   [2];
  logic [7:0] d0_v   [2];
  logic [7:0] d1_v   [2];
  logic       stb_o  [2];
  logic       ack0_o [2];
  logic       ack1_o [2];
  logic [7:0] dat_o  [2];
  logic [1:0] gnt_o  [2];

  int     gap_of [2] = '{16, 0};
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  prewish_mask_arbiter #(.GAP_CYCLES(16), .MASK_W(8)) u_dut16 (
    .CLK_I(clk), .RST_I(rst_v[0]),
    .REQ0_STB_I(s0_v[0]), .REQ0_DAT_I(d0_v[0]), .REQ0_ACK_O(ack0_o[0]),
    .REQ1_STB_I(s1_v[0]), .REQ1_DAT_I(d1_v[0]), .REQ1_ACK_O(ack1_o[0]),
    .STB_O(stb_o[0]), .DAT_O(dat_o[0]), .GNT_O(gnt_o[0])
  );

  prewish_mask_arbiter #(.GAP_CYCLES(0), .MASK_W(8)) u_dut0 (
    .CLK_I(clk), .RST_I(rst_v[1]),
    .REQ0_STB_I(s0_v[1]), .REQ0_DAT_I(d0_v[1]), .REQ0_ACK_O(ack0_o[1]),
    .REQ1_STB_I(s1_v[1]), .REQ1_DAT_I(d1_v[1]), .REQ1_ACK_O(ack1_o[1]),
    .STB_O(stb_o[1]), .DAT_O(dat_o[1]), .GNT_O(gnt_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: a load is possible only once the previous load plus its gap and one idle
  // sampling cycle have elapsed; a requester counts once it has been seen low since its last grant.
  bit         m_seen [2][2];
  int         m_last [2];
  longint     m_earliest [2];
  bit         m_stb  [2];
  bit         m_ack0 [2];
  bit         m_ack1 [2];
  logic [7:0] m_dat  [2];
  logic [1:0] m_gnt  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        m_stb[k] = 0; m_ack0[k] = 0; m_ack1[k] = 0;
        m_dat[k] = '0; m_gnt[k] = '0;
        m_seen[k][0] = 0; m_seen[k][1] = 0;
        m_last[k] = 1;
        m_earliest[k] = cyc + 1;
      end else begin
        bit e0, e1;
        int w;
        e0 = s0_v[k] && m_seen[k][0];
        e1 = s1_v[k] && m_seen[k][1];
        m_stb[k] = 0; m_ack0[k] = 0; m_ack1[k] = 0;
        if ((e0 || e1) && (cyc >= m_earliest[k])) begin
`ifdef PREWISH_ARB_FIXED_PRIO_EN
          w = e0 ? 0 : 1;
`else
          w = (e0 && e1) ? (1 - m_last[k]) : (e0 ? 0 : 1);
`endif
          m_stb[k] = 1;
          if (w == 0) begin
            m_ack0[k] = 1; m_dat[k] = d0_v[k]; m_gnt[k] = 2'b01;
          end else begin
            m_ack1[k] = 1; m_dat[k] = d1_v[k]; m_gnt[k] = 2'b10;
          end
          m_last[k] = w;
          m_seen[k][w] = 0;
          m_earliest[k] = cyc + gap_of[k] + 2;
        end
        if (!s0_v[k]) m_seen[k][0] = 1;
        if (!s1_v[k]) m_seen[k][1] = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("g%0d_stb", gap_of[k]),  32'(stb_o[k]),  32'(m_stb[k]));
        check_eq($sformatf("g%0d_ack0", gap_of[k]), 32'(ack0_o[k]), 32'(m_ack0[k]));
        check_eq($sformatf("g%0d_ack1", gap_of[k]), 32'(ack1_o[k]), 32'(m_ack1[k]));
        check_eq($sformatf("g%0d_dat", gap_of[k]),  32'(dat_o[k]),  32'(m_dat[k]));
        check_eq($sformatf("g%0d_gnt", gap_of[k]),  32'(gnt_o[k]),  32'(m_gnt[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_stb(input int k, input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      tick(1);
      if (stb_o[k]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pulses;
    int acks;
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1; s0_v[k] = 1; s1_v[k] = 1; d0_v[k] = 8'h11; d1_v[k] = 8'h22;
    end

    // Reset held with both strobes high, then no load until each strobe drops.
    repeat (3) begin
      tick(1);
      check_eq("rst_stb", 32'(stb_o[0]), 0);
      check_eq("rst_dat", 32'(dat_o[0]), 0);
      check_eq("rst_gnt", 32'(gnt_o[0]), 0);
    end
    rst_v[0] = 0; rst_v[1] = 0;
    repeat (4) begin
      tick(1);
      check_eq("unarmed_stb", 32'(stb_o[0]), 0);
    end

    // Tie on the GAP_CYCLES=16 instance.
    s0_v[0] = 0; s1_v[0] = 0; tick(1);
    s0_v[0] = 1; d0_v[0] = 8'hA8; s1_v[0] = 1; d1_v[0] = 8'hCA; tick(1);
    check_eq("tie1_stb", 32'(stb_o[0]), 1);
    check_eq("tie1_dat", 32'(dat_o[0]), 32'h A8);
    check_eq("tie1_gnt", 32'(gnt_o[0]), 32'h1);
    check_eq("tie1_ack0", 32'(ack0_o[0]), 1);
    s0_v[0] = 0; tick(1);
    check_eq("single_stb_low", 32'(stb_o[0]), 0);
    check_eq("single_dat_hold", 32'(dat_o[0]), 32'hA8);
`ifdef PREWISH_ARB_FIXED_PRIO_EN
    s0_v[0] = 1;
`endif
    wait_stb(0, 40, n);
    check_eq("tie2_delay", 32'(n), 17);
`ifdef PREWISH_ARB_FIXED_PRIO_EN
    check_eq("tie2_dat", 32'(dat_o[0]), 32'hA8);
    check_eq("tie2_gnt", 32'(gnt_o[0]), 32'h1);
`else
    check_eq("tie2_dat", 32'(dat_o[0]), 32'hCA);
    check_eq("tie2_gnt", 32'(gnt_o[0]), 32'h2);
`endif
    s0_v[0] = 0; s1_v[0] = 0; tick(20);

    // Long strobe on requester 1.
    s1_v[0] = 1; d1_v[0] = 8'hCA;
    pulses = 0; acks = 0;
    for (int i = 0; i < 811; i++) begin
      tick(1);
      if (stb_o[0]) pulses++;
      if (ack1_o[0]) acks++;
    end
    check_eq("long_pulses", 32'(pulses), 1);
    check_eq("long_acks", 32'(acks), 1);
    s1_v[0] = 0; tick(1);
    s1_v[0] = 1; wait_stb(0, 5, n);
    check_eq("relaunch_delay", 32'(n), 1);
    check_eq("relaunch_ack1", 32'(ack1_o[0]), 1);
    s1_v[0] = 0; tick(20);

    // Reset in the middle of the gap.
    s0_v[0] = 1; d0_v[0] = 8'h3C; tick(1);
    check_eq("pregap_stb", 32'(stb_o[0]), 1);
    s0_v[0] = 0; tick(5);
    rst_v[0] = 1; tick(1);
    check_eq("gaprst_dat", 32'(dat_o[0]), 0);
    check_eq("gaprst_gnt", 32'(gnt_o[0]), 0);
    rst_v[0] = 0; tick(1);
    s0_v[0] = 1; d0_v[0] = 8'h5A; tick(1);
    check_eq("postrst_stb", 32'(stb_o[0]), 1);
    check_eq("postrst_dat", 32'(dat_o[0]), 32'h5A);
    s0_v[0] = 0; tick(20);

    // GAP_CYCLES=0: alternating loads two cycles apart.
    s0_v[1] = 0; s1_v[1] = 0; tick(1);
    s0_v[1] = 1; d0_v[1] = 8'hA8; s1_v[1] = 1; d1_v[1] = 8'hCA; tick(1);
    check_eq("g0_first_dat", 32'(dat_o[1]), 32'hA8);
    s0_v[1] = 0;
    wait_stb(1, 10, n);
    check_eq("g0_spacing", 32'(n), 2);
    check_eq("g0_second_dat", 32'(dat_o[1]), 32'hCA);
    s1_v[1] = 0; tick(4);

    // Random traffic on both instances.
    repeat (2500) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rst_v[k] = ($urandom_range(0, 99) < 2);
        if (s0_v[k]) begin
          if ($urandom_range(0, 3) == 0) s0_v[k] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          s0_v[k] = 1; d0_v[k] = 8'($urandom);
        end
        if (s1_v[k]) begin
          if ($urandom_range(0, 3) == 0) s1_v[k] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          s1_v[k] = 1; d1_v[k] = 8'($urandom);
        end
      end
    end
    rst_v[0] = 0; rst_v[1] = 0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
